// File: rtl/intr_pkg.sv
// Shared constants and types for the interrupt request-conditioning stage and
// its neighbour INTR_CNTRL (bus codes, source count, snoop FSM encoding).
package intr_pkg;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;

  // Upper five bits of the words seen on the shared interrupt bus.
  localparam logic [4:0] EOI_POLL = 5'b10100;
  localparam logic [4:0] EOI_PRIO = 5'b01100;
  localparam logic [4:0] VEC_POLL = 5'b01011;
  localparam logic [4:0] VEC_PRIO = 5'b10011;

  typedef enum logic [1:0] {
    SNOOP_IDLE = 2'd0,
    SNOOP_VEC  = 2'd1,
    SNOOP_ISR  = 2'd2
  } snoop_state_e;

  function automatic logic is_eoi_code(input logic [4:0] code);
    return (code == EOI_POLL) || (code == EOI_PRIO);
  endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// One source line: multi-flop synchroniser followed by a rising-edge detector
// on the synchronised level.
module intr_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic s_out,
  output logic rise_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign s_out    = sync_q[SYNC_STAGES-1];
  assign rise_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intr_rq_cond.sv
// Conditions raw interrupt sources for INTR_CNTRL: synchronise, level/edge
// capture, masking, overflow tracking and EOI-driven clearing via bus snoop.
module intr_rq_cond #(
  parameter int NUM_SRC     = intr_pkg::NUM_SRC,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic               cfg_we,
  input  logic               cfg_sel,
  input  logic [NUM_SRC-1:0] cfg_data,
  input  logic [7:0]         intr_bus,
  input  logic               bus_oe,
  input  logic               intr_in,
  input  logic               clr_lost,
  output logic [NUM_SRC-1:0] intr_rq,
  output logic [NUM_SRC-1:0] lost,
  output logic               eoi_seen
);

  import intr_pkg::*;

  logic [NUM_SRC-1:0] s, rise;

  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] edge_mode_q, edge_mode_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] lost_q, lost_d;
  snoop_state_e       state_q, state_d;
  logic               intr_prev_q, intr_prev_d;
  logic               eoi_seen_q, eoi_seen_d;

  logic               strobe, accept;
  logic [ID_W-1:0]    eoi_id;
  logic [NUM_SRC-1:0] eoi_clr, mode_chg, edge_set, ovf, pend_edge;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    intr_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .d_in     (src_in[i]),
      .s_out    (s[i]),
      .rise_out (rise[i])
    );
  end

  // Snoop FSM: an EOI only counts after a vector fetch has been seen, so a
  // stale EOI word lingering on the bus in IDLE cannot clear anything.
  always_comb begin
    strobe      = intr_prev_q & ~intr_in;
    accept      = (state_q == SNOOP_ISR) & strobe & ~bus_oe
                  & is_eoi_code(intr_bus[7:3]);
    eoi_id      = intr_bus[ID_W-1:0];
    eoi_clr     = accept ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << eoi_id) : '0;
    intr_prev_d = intr_in;
    eoi_seen_d  = accept;
    state_d     = state_q;
    case (state_q)
      SNOOP_IDLE: if (bus_oe)  state_d = SNOOP_VEC;
      SNOOP_VEC:  if (!bus_oe) state_d = SNOOP_ISR;
      SNOOP_ISR:  if (accept)  state_d = SNOOP_IDLE;
      default:                 state_d = SNOOP_IDLE;
    endcase
  end

  always_comb begin
    mask_d      = mask_q;
    edge_mode_d = edge_mode_q;
    mode_chg    = '0;
    if (cfg_we) begin
      if (cfg_sel) begin
        edge_mode_d = cfg_data;
        mode_chg    = cfg_data ^ edge_mode_q;
      end else begin
        mask_d = cfg_data;
      end
    end
  end

  // A rise beats a same-cycle EOI, and that collision is not an overflow.
  always_comb begin
    edge_set  = edge_mode_q & rise;
    ovf       = edge_set & pending_q & ~eoi_clr;
    pend_edge = edge_set | (pending_q & ~eoi_clr);
    pending_d = ((edge_mode_q & pend_edge) | (~edge_mode_q & s)) & ~mode_chg;
    lost_d    = ((lost_q & ~{NUM_SRC{clr_lost}}) | ovf) & ~mode_chg;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mask_q      <= '0;
      edge_mode_q <= '0;
      pending_q   <= '0;
      lost_q      <= '0;
      state_q     <= SNOOP_IDLE;
      intr_prev_q <= 1'b0;
      eoi_seen_q  <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      edge_mode_q <= edge_mode_d;
      pending_q   <= pending_d;
      lost_q      <= lost_d;
      state_q     <= state_d;
      intr_prev_q <= intr_prev_d;
      eoi_seen_q  <= eoi_seen_d;
    end
  end

  assign intr_rq  = pending_q & ~mask_q;
  assign lost     = lost_q;
  assign eoi_seen = eoi_seen_q;

endmodule
